regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-read-port integer register file with same-cycle write->read bypass,
//  a per-register busy scoreboard for pipelined issue, and a sequential clear engine.

---
 rtl/regfile_mp_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with same-cycle write->read bypass,
// per-register busy scoreboard and a sequential clear engine.
// Register 0 is hard-wired to zero and is never marked busy.
module regfile_mp_scoreboard #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr
);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e             state_q;
  logic [AW-1:0]      clr_cnt_q;
  logic [NREGS-1:0]   busy_q;
  logic [NREGS-1:0]   busy_d;
  logic               ready_q;
  logic [XLEN-1:0]    mem_q [NREGS];

  // Scoreboard next state: a writeback retires a producer, an issue installs
  // a new one; applying the issue last lets the newer producer win.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Control FSM: clear sweep after reset or on request, then normal operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NREGS - 1)) begin
            state_q   <= S_READY;
            ready_q   <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        S_READY: begin
          if (clear_req) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= '0;
            ready_q   <= 1'b0;
          end else begin
            busy_q <= busy_d;
          end
        end
        default: begin
          state_q   <= S_CLEAR;
          clr_cnt_q <= '0;
          busy_q    <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroed one word per cycle while clearing, else writeback.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign ready = ready_q;

  // Combinational read ports with optional same-cycle writeback forwarding.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if ((state_q == S_READY) && (ra != '0)) begin
        if ((BYPASS != 0) && wr_en && (wr_addr == ra)) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
          rd_busy[p]              = iss_en && (iss_addr == ra);
        end else begin
          rd_data[p*XLEN +: XLEN] = mem_q[ra];
          rd_busy[p]              = busy_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: two instances (2 ports with bypass,
// 4 ports without bypass) share write/issue/clear stimulus and are checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_regfile_mp_scoreboard;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear_req = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         iss_en = 1'b0;
  logic [4:0]   iss_addr = '0;
  logic [9:0]   ra_a = '0;
  logic [19:0]  ra_b = '0;
  logic         ready_a, ready_b;
  logic [63:0]  rd_a;
  logic [127:0] rd_b;
  logic [1:0]   busy_a;
  logic [3:0]   busy_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_a),
    .rd_addr(ra_a), .rd_data(rd_a), .rd_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_b),
    .rd_addr(ra_b), .rd_data(rd_b), .rd_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  // Behavioural model: register contents, busy flags and how many clear
  // cycles remain before the file is usable again.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          m_clear_left = 32;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clear_left = 32;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (m_clear_left > 0) begin
      m_reg[32 - m_clear_left] = '0;
      m_clear_left--;
    end else if (clear_req) begin
      m_clear_left = 32;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(bit byp, logic [4:0] a);
    if (m_clear_left != 0 || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(bit byp, logic [4:0] a);
    if (m_clear_left != 0 || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return iss_en && iss_addr == a;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready_a", 128'(ready_a), 128'(m_clear_left == 0));
      chk("ready_b", 128'(ready_b), 128'(m_clear_left == 0));
      for (int p = 0; p < 2; p++) begin
        chk("a.rd_data", 128'(rd_a[p*32 +: 32]), 128'(exp_data(1'b1, ra_a[p*5 +: 5])));
        chk("a.rd_busy", 128'(busy_a[p]), 128'(exp_busy(1'b1, ra_a[p*5 +: 5])));
      end
      for (int p = 0; p < 4; p++) begin
        chk("b.rd_data", 128'(rd_b[p*32 +: 32]), 128'(exp_data(1'b0, ra_b[p*5 +: 5])));
        chk("b.rd_busy", 128'(busy_b[p]), 128'(exp_busy(1'b0, ra_b[p*5 +: 5])));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!ready_a && n < 100) begin
      cyc();
      n++;
    end
    chk(name, 128'(n), 128'(32));
  endtask

  task automatic t2_check();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc();
    idle();
    ra_a = {5'd5, 5'd5};
    ra_b = {4{5'd5}};
    @(negedge clk);
    chk("T2 a both ports", 128'(rd_a), 128'({2{32'hDEADBEEF}}));
    chk("T2 b four ports", rd_b, {4{32'hDEADBEEF}});
    cyc();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1;
    cyc();
    idle();
    ra_a = '0; ra_b = '0;
    @(negedge clk);
    chk("T2 x0 reads 0", 128'(rd_a), 128'(0));
    cyc();
  endtask

  initial begin
    logic [4:0] a;
    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    cyc();
    // T1: reset release and clear duration
    rst = 1'b1;
    chk("T1 ready low", 128'(ready_a), 128'(0));
    count_clear("T1 clear cycles");
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      ra_a = {a, a}; ra_b = {4{a}};
      @(negedge clk);
      chk("T1 read zero", 128'({rd_b, rd_a}), 128'(0));
      cyc();
    end
    // T2
    t2_check();
    // T3: same-cycle forwarding (bypass) versus old value (no bypass)
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    ra_a = {5'd0, 5'd7}; ra_b = {15'd0, 5'd7};
    @(negedge clk);
    chk("T3 bypass", 128'(rd_a[31:0]), 128'(32'h1234));
    chk("T3 no bypass", 128'(rd_b[31:0]), 128'(0));
    cyc();
    idle();
    @(negedge clk);
    chk("T3 stored", 128'(rd_b[31:0]), 128'(32'h1234));
    cyc();
    // T4: scoreboard
    iss_en = 1'b1; iss_addr = 5'd9;
    ra_a = {5'd0, 5'd9}; ra_b = {15'd0, 5'd9};
    cyc();
    idle();
    @(negedge clk);
    chk("T4 busy after issue", 128'({busy_b[0], busy_a[0]}), 128'(2'b11));
    cyc();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    cyc();
    idle();
    @(negedge clk);
    chk("T4 busy after wb", 128'({busy_b[0], busy_a[0]}), 128'(2'b00));
    cyc();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    chk("T4 bypass busy", 128'(busy_a[0]), 128'(1));
    cyc();
    idle();
    @(negedge clk);
    chk("T4 iss+wr busy", 128'({busy_b[0], busy_a[0]}), 128'(2'b11));
    chk("T4 iss+wr data", 128'(rd_a[31:0]), 128'(32'h55));
    cyc();
    // T5: fill, then clear on request with writes/issues ignored meanwhile
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = $urandom;
      iss_en = 1'b1; iss_addr = 5'(32 - i);
      cyc();
    end
    idle();
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("T5 ready drops", 128'(ready_a), 128'(0));
    begin
      int n;
      n = 0;
      while (!ready_a && n < 100) begin
        wr_en = 1'b1; wr_addr = 5'($urandom); wr_data = $urandom;
        iss_en = 1'b1; iss_addr = 5'($urandom);
        clear_req = $urandom_range(0, 1) == 1;
        cyc();
        n++;
      end
      chk("T5 clear cycles", 128'(n), 128'(32));
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      ra_a = {a, a}; ra_b = {4{a}};
      @(negedge clk);
      chk("T5 regs zero", 128'({rd_b, rd_a}), 128'(0));
      chk("T5 busy zero", 128'({busy_b, busy_a}), 128'(0));
      cyc();
    end
    // T6: reset asserted mid-clear restarts a full clear
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5;
    cyc();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (10) cyc();
    #1 rst = 1'b0;
    #1;
    chk("T6 ready low in reset", 128'({ready_b, ready_a}), 128'(0));
    cyc();
    rst = 1'b1;
    count_clear("T6 clear cycles");
    t2_check();
    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      iss_en = $urandom_range(0, 2) == 0;
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      clear_req = $urandom_range(0, 199) == 0;
      for (int p = 0; p < 2; p++)
        ra_a[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      for (int p = 0; p < 4; p++)
        ra_b[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      cyc();
    end
    idle();
    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
